// File: rtl/branch_predictor_gshare.sv
// gshare direction predictor: PC xor global history indexes a table of saturating counters.
// Latency: prediction registered, valid 1 cycle after an accepted request; table self-initialises for 2**IDX_W cycles after reset.
// Backpressure: none; requests are ignored while not ready and dropped in a cycle that carries a mispredict repair.
module branch_predictor_gshare #(
    parameter int PC_W     = 16,
    parameter int IDX_W    = 8,
    parameter int HIST_W   = 8,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 1,
    parameter int CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RES,
    output logic              ready,
    input  logic              predict_valid,
    input  logic [PC_W-1:0]   predict_pc,
    output logic              predict_out_valid,
    output logic              predict_taken,
    output logic [HIST_W-1:0] predict_history,
    input  logic              train_valid,
    input  logic [PC_W-1:0]   train_pc,
    input  logic [HIST_W-1:0] train_history,
    input  logic              train_taken,
    input  logic              train_mispredicted,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  pred_count,
    output logic [CNT_W-1:0]  mispred_count
);

    localparam int                 DEPTH    = 1 << IDX_W;
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
    localparam logic [CTR_W-1:0]   CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]   CTR_ZERO = '0;
    localparam logic [CTR_W-1:0]   CTR_ONE  = CTR_W'(1);
    localparam logic [CTR_W-1:0]   CTR_INIT = CTR_W'(INIT_CTR);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   init_ptr;
    logic [HIST_W-1:0]  ghr;
    logic [CTR_W-1:0]   ctr_mem [DEPTH];

    logic               run;
    logic               mispredict;
    logic               pred_accept;
    logic               train_do;
    logic [IDX_W-1:0]   pred_idx;
    logic [IDX_W-1:0]   train_idx;
    logic [CTR_W-1:0]   train_ctr;
    logic [CTR_W-1:0]   train_ctr_upd;

    // PC bits above the index are not part of the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{predict_pc[PC_W-1:IDX_W], train_pc[PC_W-1:IDX_W]};

    assign run         = (state == S_RUN);
    assign ready       = run;
    assign mispredict  = run & train_valid & train_mispredicted;
    // A history repair in the same cycle makes the request's history stale, so it is dropped.
    assign pred_accept = run & predict_valid & ~mispredict;
    assign train_do    = run & train_valid;
    assign pred_idx    = predict_pc[IDX_W-1:0] ^ IDX_W'(ghr);
    assign train_idx   = train_pc[IDX_W-1:0] ^ IDX_W'(train_history);
    assign train_ctr   = ctr_mem[train_idx];

    // Saturating counter step for the resolved branch.
    always_comb begin
        train_ctr_upd = train_ctr;
        if (train_taken) begin
            if (train_ctr != CTR_MAX) train_ctr_upd = train_ctr + CTR_ONE;
        end else begin
            if (train_ctr != CTR_ZERO) train_ctr_upd = train_ctr - CTR_ONE;
        end
    end

    // Init sweep finishes after the last table entry is written.
    always_comb begin
        state_nxt = state;
        if (state == S_INIT && init_ptr == IDX_LAST) state_nxt = S_RUN;
    end

    // FSM state and init sweep pointer.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state    <= S_INIT;
            init_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) init_ptr <= init_ptr + IDX_ONE;
        end
    end

    // Counter table: init sweep has the write port, then training owns it.
    always_ff @(posedge CLK) begin
        if (state == S_INIT) begin
            ctr_mem[init_ptr] <= CTR_INIT;
        end else if (train_do) begin
            ctr_mem[train_idx] <= train_ctr_upd;
        end
    end

    // Registered prediction; reads the pre-update counter on a same-index train.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            predict_out_valid <= 1'b0;
            predict_taken     <= 1'b0;
            predict_history   <= '0;
        end else begin
            predict_out_valid <= pred_accept;
            if (pred_accept) begin
                predict_taken   <= ctr_mem[pred_idx][CTR_W-1];
                predict_history <= ghr;
            end
        end
    end

    // Global history: repair on mispredict beats the speculative shift of a presented prediction.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            ghr <= '0;
        end else if (mispredict) begin
            ghr <= {train_history[HIST_W-2:0], train_taken};
        end else if (predict_out_valid) begin
            ghr <= {ghr[HIST_W-2:0], predict_taken};
        end
    end

    // Saturating statistics; clear wins over increment.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            pred_count    <= '0;
            mispred_count <= '0;
        end else if (stats_clr) begin
            pred_count    <= '0;
            mispred_count <= '0;
        end else begin
            if (pred_accept && pred_count != CNT_MAX) pred_count <= pred_count + CNT_ONE;
            if (mispredict && mispred_count != CNT_MAX) mispred_count <= mispred_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for the gshare predictor with hand-computed expectations.
// Statistics counters are narrowed to 4 bits so saturation is reachable.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_branch_predictor_gshare;

    logic        clk;
    logic        res_n;
    logic        ready;
    logic        predict_valid;
    logic [15:0] predict_pc;
    logic        predict_out_valid;
    logic        predict_taken;
    logic [7:0]  predict_history;
    logic        train_valid;
    logic [15:0] train_pc;
    logic [7:0]  train_history;
    logic        train_taken;
    logic        train_mispredicted;
    logic        stats_clr;
    logic [3:0]  pred_count;
    logic [3:0]  mispred_count;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor_gshare #(
        .PC_W(16), .IDX_W(8), .HIST_W(8), .CTR_W(2), .INIT_CTR(1), .CNT_W(4)
    ) dut (
        .CLK                (clk),
        .RES                (res_n),
        .ready              (ready),
        .predict_valid      (predict_valid),
        .predict_pc         (predict_pc),
        .predict_out_valid  (predict_out_valid),
        .predict_taken      (predict_taken),
        .predict_history    (predict_history),
        .train_valid        (train_valid),
        .train_pc           (train_pc),
        .train_history      (train_history),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .stats_clr          (stats_clr),
        .pred_count         (pred_count),
        .mispred_count      (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        predict_valid      = 1'b0;
        predict_pc         = '0;
        train_valid        = 1'b0;
        train_pc           = '0;
        train_history      = '0;
        train_taken        = 1'b0;
        train_mispredicted = 1'b0;
        stats_clr          = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < 1000) begin
            tick();
            cyc++;
        end
    endtask

    // Single request; returns the registered result one cycle later.
    task automatic predict(input logic [15:0] pc, output logic vld, output logic tkn, output logic [7:0] hist);
        predict_valid = 1'b1;
        predict_pc    = pc;
        tick();
        predict_valid = 1'b0;
        vld  = predict_out_valid;
        tkn  = predict_taken;
        hist = predict_history;
    endtask

    task automatic train(input logic [15:0] pc, input logic [7:0] hist, input logic tkn);
        train_valid        = 1'b1;
        train_mispredicted = 1'b0;
        train_pc           = pc;
        train_history      = hist;
        train_taken        = tkn;
        tick();
        train_valid = 1'b0;
    endtask

    // Forces ghr to 0 or 1 through a mispredict repair on a scratch entry.
    task automatic set_ghr(input logic h);
        train_valid        = 1'b1;
        train_mispredicted = 1'b1;
        train_pc           = 16'h00F0;
        train_history      = 8'h00;
        train_taken        = h;
        tick();
        train_valid        = 1'b0;
        train_mispredicted = 1'b0;
    endtask

    initial begin
        int         cyc;
        logic       v;
        logic       t;
        logic [7:0] h;

        res_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        check("rst_ready", ready, 0);
        check("rst_out_valid", predict_out_valid, 0);
        check("rst_taken", predict_taken, 0);
        check("rst_history", predict_history, 0);
        check("rst_pred_count", pred_count, 0);
        check("rst_mispred_count", mispred_count, 0);

        // Requests and a mispredict during the sweep must be ignored.
        predict_valid      = 1'b1;
        predict_pc         = 16'h0010;
        train_valid        = 1'b1;
        train_mispredicted = 1'b1;
        train_taken        = 1'b1;
        train_history      = 8'h55;
        res_n = 1'b1;
        wait_ready(cyc);
        idle_inputs();
        check("init_len", cyc, 256);
        check("init_pred_count", pred_count, 0);
        check("init_mispred_count", mispred_count, 0);
        check("init_out_valid", predict_out_valid, 0);

        // Every entry at weakly not-taken: nothing predicts taken, ghr stays 0.
        for (int i = 0; i < 256; i++) begin
            predict_valid = 1'b1;
            predict_pc    = 16'(i);
            tick();
            check("sweep_valid", predict_out_valid, 1);
            check("sweep_taken", predict_taken, 0);
            check("sweep_history", predict_history, 0);
        end
        predict_valid = 1'b0;
        tick();
        check("pred_count_sat_256", pred_count, 15);

        // Clear wins over a simultaneous accepted request.
        stats_clr     = 1'b1;
        predict_valid = 1'b1;
        predict_pc    = 16'h0055;
        tick();
        stats_clr = 1'b0;
        check("stats_clr", pred_count, 0);
        repeat (15) tick();
        check("pred_count_15", pred_count, 15);
        tick();
        check("pred_count_hold", pred_count, 15);
        predict_valid = 1'b0;
        tick();

        // Saturation at pc 0x0010, history 0.
        train(16'h0010, 8'h00, 1'b1);
        predict(16'h0010, v, t, h);
        check("sat_1_taken", t, 1);
        check("sat_1_history", h, 0);
        tick();
        check("pulse_low", predict_out_valid, 0);
        check("hold_taken", predict_taken, 1);
        set_ghr(1'b0);
        repeat (3) train(16'h0010, 8'h00, 1'b1);
        predict(16'h0010, v, t, h);
        check("sat_4t_taken", t, 1);
        set_ghr(1'b0);
        train(16'h0010, 8'h00, 1'b0);
        predict(16'h0010, v, t, h);
        check("sat_4t1n_taken", t, 1);
        set_ghr(1'b0);
        train(16'h0010, 8'h00, 1'b0);
        predict(16'h0010, v, t, h);
        check("sat_4t2n_taken", t, 0);
        repeat (3) train(16'h0010, 8'h00, 1'b0);
        train(16'h0010, 8'h00, 1'b1);
        predict(16'h0010, v, t, h);
        check("sat_floor_taken", t, 0);
        set_ghr(1'b0);

        // History: predictions 1,1,0 from ghr=0 give 0x06; repair gives 0x0D.
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        train(16'h0020, 8'h00, 1'b1);
        train(16'h0030, 8'h01, 1'b1);
        predict(16'h0020, v, t, h);
        check("hist_p1_taken", t, 1);
        check("hist_p1_history", h, 8'h00);
        tick();
        predict(16'h0030, v, t, h);
        check("hist_p2_taken", t, 1);
        check("hist_p2_history", h, 8'h01);
        tick();
        predict(16'h0040, v, t, h);
        check("hist_p3_taken", t, 0);
        check("hist_p3_history", h, 8'h03);
        tick();
        predict(16'h0080, v, t, h);
        check("hist_after_110", h, 8'h06);
        // Repair lands in the cycle the 0x0080 result is presented; its shift is discarded.
        train_valid        = 1'b1;
        train_mispredicted = 1'b1;
        train_pc           = 16'h0090;
        train_history      = 8'h06;
        train_taken        = 1'b1;
        tick();
        train_valid        = 1'b0;
        train_mispredicted = 1'b0;
        predict(16'h0000, v, t, h);
        check("hist_repaired", h, 8'h0D);
        check("mispred_count_1", mispred_count, 1);
        check("pred_count_5", pred_count, 5);
        // Back-to-back: second request sees ghr before the first one's shift.
        predict(16'h0001, v, t, h);
        check("b2b_history", h, 8'h0D);
        predict(16'h0002, v, t, h);
        check("b2b_next_history", h, 8'h1A);
        set_ghr(1'b0);

        // Aliasing: pc 3 with ghr 1 and pc 2 with ghr 0 share index 2.
        set_ghr(1'b1);
        predict(16'h0003, v, t, h);
        check("alias_before_taken", t, 0);
        check("alias_before_history", h, 8'h01);
        set_ghr(1'b0);
        train(16'h0002, 8'h00, 1'b1);
        set_ghr(1'b1);
        predict(16'h0003, v, t, h);
        check("alias_after_taken", t, 1);
        set_ghr(1'b0);

        // Predict colliding with a mispredict is dropped and not counted.
        stats_clr = 1'b1;
        tick();
        stats_clr          = 1'b0;
        predict_valid      = 1'b1;
        predict_pc         = 16'h0060;
        train_valid        = 1'b1;
        train_mispredicted = 1'b1;
        train_pc           = 16'h00F0;
        train_history      = 8'h00;
        train_taken        = 1'b0;
        tick();
        idle_inputs();
        check("drop_out_valid", predict_out_valid, 0);
        check("drop_pred_count", pred_count, 0);
        check("drop_mispred_count", mispred_count, 1);

        // Same-index predict and train: old counter returned, write still lands.
        train(16'h0050, 8'h00, 1'b1);
        predict_valid = 1'b1;
        predict_pc    = 16'h0050;
        train_valid   = 1'b1;
        train_pc      = 16'h0050;
        train_history = 8'h00;
        train_taken   = 1'b0;
        tick();
        idle_inputs();
        check("same_idx_valid", predict_out_valid, 1);
        check("same_idx_old_taken", predict_taken, 1);
        set_ghr(1'b0);
        predict(16'h0050, v, t, h);
        check("same_idx_new_taken", t, 0);

        // Reset in the middle of the init sweep restarts it from entry 0.
        res_n = 1'b0;
        tick();
        check("rst2_ready", ready, 0);
        check("rst2_pred_count", pred_count, 0);
        res_n = 1'b1;
        repeat (100) tick();
        check("mid_init_ready", ready, 0);
        res_n = 1'b0;
        tick();
        res_n = 1'b1;
        wait_ready(cyc);
        check("reinit_len", cyc, 256);
        predict(16'h0096, v, t, h);
        check("reinit_valid", v, 1);
        check("reinit_taken", t, 0);
        check("reinit_history", h, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
